// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//   Debug read-out engine for the CPU register file. A start pulse in IDLE
//   latches an inclusive address range [first_addr .. last_addr]. The range
//   wraps modulo 2**ADDR_W. The engine then walks the range through a spare
//   combinational read port and streams one (addr, data) beat per register
//   on a valid/ready output. It uses its own read port, so the CPU datapath
//   read ports are never disturbed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a dump; only looked at in IDLE
//   first_addr first register of the range (latched on accepted start)
//   last_addr  last register of the range, inclusive (latched on accepted start)
//   abort      synchronous cancel from any state, higher priority than start
//   rd_addr    address presented to the register-file read port
//   rd_data    combinational read data for rd_addr
//   out_valid  beat available
//   out_ready  sink accepts the beat at posedge when out_valid is high
//   out_addr   register index of the current beat
//   out_data   register value of the current beat
//   busy       high while scanning or draining the final beat
//   done       one-cycle pulse after the final beat has been accepted
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   cur_reg;
    // One bit wider than the address so a full 2**ADDR_W walk fits.
    logic [ADDR_W:0]     remaining_reg;
    logic                out_valid_reg;
    logic [ADDR_W-1:0]   out_addr_reg;
    logic [DATA_W-1:0]   out_data_reg;

    logic [ADDR_W-1:0]   span;
    logic                start_ok;
    logic                capture;
    logic                last_capture;
    logic                accept;

    // Modular distance between the range ends; +1 gives the beat count.
    assign span     = last_addr - first_addr;
    assign start_ok = (state_reg == ST_IDLE) && start && !abort;
    assign accept   = out_valid_reg && out_ready;

    // The output register can take a new value when it is empty or is being
    // emptied at this same edge. That gives one beat per cycle under ready.
    assign capture      = (state_reg == ST_SCAN) && !abort && (!out_valid_reg || out_ready);
    assign last_capture = capture && (remaining_reg == {{ADDR_W{1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (start)        state_next = ST_SCAN;
                ST_SCAN:  if (last_capture) state_next = ST_DRAIN;
                ST_DRAIN: if (accept)       state_next = ST_DONE;
                ST_DONE:                    state_next = ST_IDLE;
                default:                    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_reg       <= '0;
            remaining_reg <= '0;
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
        end else begin
            if (start_ok) begin
                cur_reg       <= first_addr;
                remaining_reg <= {1'b0, span} + {{ADDR_W{1'b0}}, 1'b1};
            end

            if (capture) begin
                // rd_data is sampled at this edge. A CPU write to the same
                // register at this edge lands afterwards, so the beat
                // carries the pre-write value.
                out_data_reg  <= rd_data;
                out_addr_reg  <= cur_reg;
                out_valid_reg <= 1'b1;
                cur_reg       <= cur_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                remaining_reg <= remaining_reg - {{ADDR_W{1'b0}}, 1'b1};
            end else if (accept) begin
                out_valid_reg <= 1'b0;
            end

            if (abort) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign rd_addr   = cur_reg;
    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg == ST_SCAN) || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    // Register file model with one write port and the spare read port.
    logic [31:0] mem [32];
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] regs_exp [32];

    int errors;
    int checks;

    regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rd_data = mem[rd_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one dump and scoreboards every accepted beat.
    // rmode: 0 = ready high, 1 = random ready, 2 = ready low for 5 cycles.
    task automatic do_dump(input string name, input logic [4:0] f, input logic [4:0] l,
                           input int rmode, input bit poke_start, input bit collide);
        logic [4:0]  d;
        int          n_exp;
        int          beats;
        int          cyc;
        int          last_hs;
        int          done_cyc;
        bit          seen_done;
        bit          wrote;
        logic [4:0]  exp_addr;
        logic        prev_stall;
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;
        d          = l - f;
        n_exp      = int'(d) + 1;
        beats      = 0;
        cyc        = 0;
        last_hs    = -100;
        done_cyc   = -1;
        seen_done  = 1'b0;
        wrote      = 1'b0;
        exp_addr   = f;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        start      = 1'b1;
        first_addr = f;
        last_addr  = l;
        out_ready  = (rmode == 2) ? 1'b0 : 1'b1;
        tick();
        start = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (prev_stall) begin
                check({name, " stall_addr"}, 64'(out_addr), 64'(prev_addr));
                check({name, " stall_data"}, 64'(out_data), 64'(prev_data));
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end else begin
                case (rmode)
                    1:       out_ready = 1'($urandom_range(0, 1));
                    2:       out_ready = (cyc >= 5);
                    default: out_ready = 1'b1;
                endcase
                // A start while busy with a different range must be ignored.
                start      = poke_start && (cyc == 4);
                first_addr = poke_start ? 5'd20 : f;
                last_addr  = poke_start ? 5'd21 : l;
                if (collide && !wrote && busy && rd_addr == 5'd7 && (!out_valid || out_ready)) begin
                    we    = 1'b1;
                    waddr = 5'd7;
                    wdata = 32'hDEADBEEF;
                    wrote = 1'b1;
                end
                if (out_valid && out_ready) begin
                    check({name, " addr"}, 64'(out_addr), 64'(exp_addr));
                    check({name, " data"}, 64'(out_data), 64'(regs_exp[exp_addr]));
                    $display("%s beat %0d addr=%0d data=%08h", name, beats, out_addr, out_data);
                    beats++;
                    exp_addr = exp_addr + 5'd1;
                    last_hs  = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_addr  = out_addr;
                prev_data  = out_data;
                tick();
                cyc++;
                we    = 1'b0;
                start = 1'b0;
            end
        end
        check({name, " done_seen"}, 64'(seen_done), 64'd1);
        check({name, " beats"}, 64'(beats), 64'(n_exp));
        check({name, " done_latency"}, 64'(done_cyc - last_hs), 64'd1);
        if (collide) check({name, " collide_written"}, 64'(wrote), 64'd1);
        tick();
        check({name, " done_single"}, 64'(done), 64'd0);
        check({name, " idle_busy"}, 64'(busy), 64'd0);
        check({name, " idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cnt;
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;

        // Preload through the write port while the engine is held in reset.
        for (int i = 0; i < 32; i++) begin
            we          = 1'b1;
            waddr       = 5'(i);
            wdata       = 32'(i) * 32'h01010101;
            regs_exp[i] = 32'(i) * 32'h01010101;
            tick();
        end
        we = 1'b0;

        check("rst rd_addr",   64'(rd_addr),   64'd0);
        check("rst out_addr",  64'(out_addr),  64'd0);
        check("rst out_data",  64'(out_data),  64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy",      64'(busy),      64'd0);
        check("rst done",      64'(done),      64'd0);
        $display("reset state checked");

        rst_n = 1'b1;
        tick();

        // Cycle-exact full dump: start is sampled at edge 0.
        start      = 1'b1;
        first_addr = 5'd0;
        last_addr  = 5'd31;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            check("full valid", 64'(out_valid), 64'((n >= 2) && (n <= 33)));
            check("full busy",  64'(busy),      64'((n >= 1) && (n <= 33)));
            check("full done",  64'(done),      64'(n == 34));
            if (out_valid) begin
                check("full addr", 64'(out_addr), 64'(n - 2));
                check("full data", 64'(out_data), 64'(32'(n - 2) * 32'h01010101));
            end
            $display("full cycle %0d valid=%0b addr=%0d data=%08h busy=%0b done=%0b",
                     n, out_valid, out_addr, out_data, busy, done);
            tick();
        end

        do_dump("wrap",   5'd30, 5'd1,  0, 1'b0, 1'b0);
        do_dump("single", 5'd5,  5'd5,  2, 1'b0, 1'b0);
        do_dump("random", 5'd0,  5'd31, 1, 1'b0, 1'b0);
        do_dump("poke",   5'd0,  5'd31, 0, 1'b1, 1'b0);

        // Abort after the third accepted beat.
        start      = 1'b1;
        first_addr = 5'd0;
        last_addr  = 5'd31;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            if (out_valid && out_ready) cnt++;
            tick();
        end
        check("abort beats_before", 64'(cnt), 64'd3);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort valid", 64'(out_valid), 64'd0);
        check("abort busy",  64'(busy),      64'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort no_done", 64'(done), 64'd0);
            check("abort stays_idle", 64'(busy), 64'd0);
            tick();
        end
        $display("abort sequence checked");

        // Write collision on register 7, then a second dump sees the new value.
        do_dump("collide", 5'd0, 5'd31, 0, 1'b0, 1'b1);
        regs_exp[7] = 32'hDEADBEEF;
        do_dump("after_collide", 5'd0, 5'd31, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a dump.
        start      = 1'b1;
        first_addr = 5'd3;
        last_addr  = 5'd20;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst out_valid", 64'(out_valid), 64'd0);
        check("arst out_addr",  64'(out_addr),  64'd0);
        check("arst out_data",  64'(out_data),  64'd0);
        check("arst rd_addr",   64'(rd_addr),   64'd0);
        check("arst busy",      64'(busy),      64'd0);
        check("arst done",      64'(done),      64'd0);
        $display("async reset mid-dump checked");
        tick();
        tick();
        check("arst held_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();
        do_dump("post_reset", 5'd0, 5'd31, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
